// File: rtl/player_action_arbiter.sv
// Round-robin arbiter that serialises both players' moves and bomb drops through
// one IDLE -> EVAL -> DONE path and owns the authoritative player/bomb registers.
module player_action_arbiter #(
    parameter int unsigned COOLDOWN = 5000000,
    parameter int unsigned CNT_W    = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          play_en,
    input  logic          a_req,
    input  logic [2:0]    a_cmd,
    output logic          a_ack,
    output logic          a_ok,
    input  logic          b_req,
    input  logic [2:0]    b_cmd,
    output logic          b_ack,
    output logic          b_ok,
    input  logic [99:0]   arena_blocks,
    input  logic          bomb_busy_a,
    input  logic          bomb_busy_b,
    output logic [3:0]    pAx,
    output logic [3:0]    pAy,
    output logic [3:0]    pBx,
    output logic [3:0]    pBy,
    output logic [3:0]    bombA_x,
    output logic [3:0]    bombA_y,
    output logic          bombA_v,
    output logic [3:0]    bombB_x,
    output logic [3:0]    bombB_y,
    output logic          bombB_v
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN);

    logic [1:0]       state_q, state_d;
    logic             gnt_b_q, gnt_b_d;
    logic             last_b_q, last_b_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [CNT_W-1:0] cd_a_q, cd_a_d, cd_b_q, cd_b_d;
    logic [3:0]       pax_q, pax_d, pay_q, pay_d, pbx_q, pbx_d, pby_q, pby_d;
    logic [3:0]       bax_q, bax_d, bay_q, bay_d, bbx_q, bbx_d, bby_q, bby_d;
    logic             bav_q, bav_d, bbv_q, bbv_d;
    logic             a_ack_q, a_ack_d, a_ok_q, a_ok_d;
    logic             b_ack_q, b_ack_d, b_ok_q, b_ok_d;

    logic [3:0] cur_x, cur_y, oth_x, oth_y, tgt_x, tgt_y;
    logic [6:0] tgt_idx;
    logic       in_bounds, is_move, blocked, collide, busy_sel, accept;
    logic       elig_a, elig_b, pick_b;

    // Evaluation of the latched command against the current registers.
    always_comb begin
        cur_x     = gnt_b_q ? pbx_q : pax_q;
        cur_y     = gnt_b_q ? pby_q : pay_q;
        oth_x     = gnt_b_q ? pax_q : pbx_q;
        oth_y     = gnt_b_q ? pay_q : pby_q;
        tgt_x     = cur_x;
        tgt_y     = cur_y;
        in_bounds = 1'b0;
        is_move   = 1'b1;
        case (cmd_q)
            3'd0: begin in_bounds = (cur_y != 4'd0); tgt_y = cur_y - 4'd1; end
            3'd1: begin in_bounds = (cur_y <  4'd9); tgt_y = cur_y + 4'd1; end
            3'd2: begin in_bounds = (cur_x != 4'd0); tgt_x = cur_x - 4'd1; end
            3'd3: begin in_bounds = (cur_x <  4'd9); tgt_x = cur_x + 4'd1; end
            default: is_move = 1'b0;
        endcase
        tgt_idx  = 7'(tgt_y) * 7'd10 + 7'(tgt_x);
        blocked  = (tgt_idx < 7'd100) ? arena_blocks[tgt_idx] : 1'b1;
        collide  = (tgt_x == oth_x) && (tgt_y == oth_y);
        busy_sel = gnt_b_q ? bomb_busy_b : bomb_busy_a;
        accept   = is_move ? (in_bounds && !blocked && !collide)
                           : ((cmd_q == 3'd4) && !busy_sel);
    end

    always_comb begin
        elig_a  = a_req && (cd_a_q == '0);
        elig_b  = b_req && (cd_b_q == '0);
        pick_b  = elig_b && (!elig_a || !last_b_q);

        state_d  = state_q;
        gnt_b_d  = gnt_b_q;
        last_b_d = last_b_q;
        cmd_d    = cmd_q;
        cd_a_d   = (cd_a_q != '0) ? cd_a_q - CNT_W'(1) : '0;
        cd_b_d   = (cd_b_q != '0) ? cd_b_q - CNT_W'(1) : '0;
        pax_d = pax_q; pay_d = pay_q; pbx_d = pbx_q; pby_d = pby_q;
        bax_d = bax_q; bay_d = bay_q; bbx_d = bbx_q; bby_d = bby_q;
        bav_d   = 1'b0;
        bbv_d   = 1'b0;
        a_ack_d = 1'b0;
        a_ok_d  = 1'b0;
        b_ack_d = 1'b0;
        b_ok_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (play_en && (elig_a || elig_b)) begin
                    gnt_b_d  = pick_b;
                    last_b_d = pick_b;
                    cmd_d    = pick_b ? b_cmd : a_cmd;
                    state_d  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_d = ST_DONE;
                if (gnt_b_q) begin
                    b_ack_d = 1'b1;
                    b_ok_d  = accept;
                    if (accept) begin
                        cd_b_d = CD_LOAD;
                        if (is_move) begin
                            pbx_d = tgt_x;
                            pby_d = tgt_y;
                        end else begin
                            bbv_d = 1'b1;
                            bbx_d = cur_x;
                            bby_d = cur_y;
                        end
                    end
                end else begin
                    a_ack_d = 1'b1;
                    a_ok_d  = accept;
                    if (accept) begin
                        cd_a_d = CD_LOAD;
                        if (is_move) begin
                            pax_d = tgt_x;
                            pay_d = tgt_y;
                        end else begin
                            bav_d = 1'b1;
                            bax_d = cur_x;
                            bay_d = cur_y;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_b_q  <= 1'b0;
            last_b_q <= 1'b1;
            cmd_q    <= '0;
            cd_a_q   <= '0;
            cd_b_q   <= '0;
            pax_q    <= 4'd1;
            pay_q    <= 4'd1;
            pbx_q    <= 4'd8;
            pby_q    <= 4'd8;
            bax_q    <= '0;
            bay_q    <= '0;
            bbx_q    <= '0;
            bby_q    <= '0;
            bav_q    <= 1'b0;
            bbv_q    <= 1'b0;
            a_ack_q  <= 1'b0;
            a_ok_q   <= 1'b0;
            b_ack_q  <= 1'b0;
            b_ok_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_b_q  <= gnt_b_d;
            last_b_q <= last_b_d;
            cmd_q    <= cmd_d;
            cd_a_q   <= cd_a_d;
            cd_b_q   <= cd_b_d;
            pax_q    <= pax_d;
            pay_q    <= pay_d;
            pbx_q    <= pbx_d;
            pby_q    <= pby_d;
            bax_q    <= bax_d;
            bay_q    <= bay_d;
            bbx_q    <= bbx_d;
            bby_q    <= bby_d;
            bav_q    <= bav_d;
            bbv_q    <= bbv_d;
            a_ack_q  <= a_ack_d;
            a_ok_q   <= a_ok_d;
            b_ack_q  <= b_ack_d;
            b_ok_q   <= b_ok_d;
        end
    end

    assign a_ack   = a_ack_q;
    assign a_ok    = a_ok_q;
    assign b_ack   = b_ack_q;
    assign b_ok    = b_ok_q;
    assign pAx     = pax_q;
    assign pAy     = pay_q;
    assign pBx     = pbx_q;
    assign pBy     = pby_q;
    assign bombA_x = bax_q;
    assign bombA_y = bay_q;
    assign bombA_v = bav_q;
    assign bombB_x = bbx_q;
    assign bombB_y = bby_q;
    assign bombB_v = bbv_q;

endmodule

// File: tb/tb_player_action_arbiter.sv
// Bench for player_action_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a timestamp-based player model.
module tb_player_action_arbiter;

    localparam int CD = 4;

    logic         clk = 1'b0;
    logic         rst, play_en, a_req, b_req, bomb_busy_a, bomb_busy_b;
    logic [2:0]   a_cmd, b_cmd;
    logic [99:0]  arena_blocks;
    logic         a_ack, a_ok, b_ack, b_ok, bombA_v, bombB_v;
    logic [3:0]   pAx, pAy, pBx, pBy, bombA_x, bombA_y, bombB_x, bombB_y;

    int errors = 0;
    int checks = 0;

    player_action_arbiter #(.COOLDOWN(CD), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .play_en(play_en),
        .a_req(a_req), .a_cmd(a_cmd), .a_ack(a_ack), .a_ok(a_ok),
        .b_req(b_req), .b_cmd(b_cmd), .b_ack(b_ack), .b_ok(b_ok),
        .arena_blocks(arena_blocks), .bomb_busy_a(bomb_busy_a), .bomb_busy_b(bomb_busy_b),
        .pAx(pAx), .pAy(pAy), .pBx(pBx), .pBy(pBy),
        .bombA_x(bombA_x), .bombA_y(bombA_y), .bombA_v(bombA_v),
        .bombB_x(bombB_x), .bombB_y(bombB_y), .bombB_v(bombB_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: positions, bombs, and cooldown expressed as "eligible from cycle N".
    int  cyc = 0;
    bit  mv = 0;
    int  m_px[2], m_py[2], m_bx[2], m_by[2], m_ready[2];
    bit  m_bv[2], m_ack[2], m_ok[2];
    int  m_last, m_who, m_cmd, m_g, m_free;
    bit  m_pend;

    task automatic model_eval();
        int p, o, nx, ny;
        bit acc;
        p = m_who; o = 1 - m_who;
        nx = m_px[p]; ny = m_py[p]; acc = 0;
        if (m_cmd <= 3) begin
            case (m_cmd)
                0: ny = ny - 1;
                1: ny = ny + 1;
                2: nx = nx - 1;
                default: nx = nx + 1;
            endcase
            acc = (nx >= 0 && nx <= 9 && ny >= 0 && ny <= 9);
            if (acc) acc = !arena_blocks[ny*10 + nx] && !(nx == m_px[o] && ny == m_py[o]);
            if (acc) begin m_px[p] = nx; m_py[p] = ny; end
        end else if (m_cmd == 4) begin
            acc = (p == 1) ? !bomb_busy_b : !bomb_busy_a;
            if (acc) begin m_bx[p] = m_px[p]; m_by[p] = m_py[p]; m_bv[p] = 1; end
        end
        m_ack[p] = 1; m_ok[p] = acc;
        if (acc) m_ready[p] = cyc + 1 + CD;
        m_pend = 0;
        m_free = cyc + 2;
    endtask

    always @(negedge clk) begin
        bit ea, eb;
        if (mv) begin
            chk("a_ack", int'(a_ack), int'(m_ack[0]));
            chk("a_ok", int'(a_ok), int'(m_ok[0]));
            chk("b_ack", int'(b_ack), int'(m_ack[1]));
            chk("b_ok", int'(b_ok), int'(m_ok[1]));
            chk("pAx", int'(pAx), m_px[0]);
            chk("pAy", int'(pAy), m_py[0]);
            chk("pBx", int'(pBx), m_px[1]);
            chk("pBy", int'(pBy), m_py[1]);
            chk("bombA_v", int'(bombA_v), int'(m_bv[0]));
            chk("bombB_v", int'(bombB_v), int'(m_bv[1]));
            chk("bombA_xy", int'(bombA_x) * 16 + int'(bombA_y), m_bx[0] * 16 + m_by[0]);
            chk("bombB_xy", int'(bombB_x) * 16 + int'(bombB_y), m_bx[1] * 16 + m_by[1]);
        end
        m_ack = '{0, 0}; m_ok = '{0, 0}; m_bv = '{0, 0};
        if (rst === 1'b1) begin
            m_px = '{1, 8}; m_py = '{1, 8}; m_bx = '{0, 0}; m_by = '{0, 0};
            m_ready = '{0, 0}; m_last = 1; m_pend = 0; m_free = cyc + 1; mv = 1;
        end else if (mv) begin
            if (m_pend && cyc == m_g + 1) begin
                model_eval();
            end else if (!m_pend && cyc >= m_free && play_en) begin
                ea = a_req && cyc >= m_ready[0];
                eb = b_req && cyc >= m_ready[1];
                if (ea || eb) begin
                    m_who  = (ea && eb) ? 1 - m_last : (eb ? 1 : 0);
                    m_last = m_who;
                    m_cmd  = (m_who == 1) ? int'(b_cmd) : int'(a_cmd);
                    m_g    = cyc;
                    m_pend = 1;
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input bit is_b, input int maxc, output int n, output bit okv);
        n = 0; okv = 0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            n++;
            if ((is_b ? b_ack : a_ack) === 1'b1) begin
                okv = is_b ? b_ok : a_ok;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL ack_timeout: no ack within %0d cycles, expected one", maxc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, acks;
        bit  okv;
        rst = 1'b1; play_en = 1'b0; a_req = 1'b0; b_req = 1'b0;
        a_cmd = '0; b_cmd = '0; arena_blocks = '0;
        bomb_busy_a = 1'b0; bomb_busy_b = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_pA", int'(pAx) * 16 + int'(pAy), 17);
        chk("rst_pB", int'(pBx) * 16 + int'(pBy), 136);
        chk("rst_ack", int'(a_ack) + int'(b_ack) + int'(bombA_v) + int'(bombB_v), 0);
        chk("rst_bomb", int'(bombA_x) + int'(bombA_y) + int'(bombB_x) + int'(bombB_y), 0);

        // Single right move: ack two cycles after the sampling cycle.
        play_en = 1'b1; a_req = 1'b1; a_cmd = 3'd3;
        tick(); a_req = 1'b0;
        chk("mv_no_early_ack", int'(a_ack), 0);
        tick();
        chk("mv_ack", int'(a_ack) * 2 + int'(a_ok), 3);
        chk("mv_pA", int'(pAx) * 16 + int'(pAy), 33);

        // Reset during EVAL: no ack, positions back to start.
        repeat (CD + 2) tick();
        a_req = 1'b1; a_cmd = 3'd1;
        tick(); rst = 1'b1; a_req = 1'b0;
        tick(); rst = 1'b0;
        chk("rst_eval_ack", int'(a_ack), 0);
        chk("rst_eval_pA", int'(pAx) * 16 + int'(pAy), 17);

        // Simultaneous requests after reset, then tie broken by last grant.
        do_reset();
        a_req = 1'b1; a_cmd = 3'd1; b_req = 1'b1; b_cmd = 3'd0;
        wait_ack(1'b0, 10, n, okv);
        chk("tie1_a_lat", n, 2); chk("tie1_a_ok", int'(okv), 1);
        chk("tie1_pAy", int'(pAy), 2);
        a_req = 1'b0;
        wait_ack(1'b1, 10, n, okv);
        chk("tie1_b_lat", n, 3); chk("tie1_pBy", int'(pBy), 7);
        b_req = 1'b0;
        repeat (4) tick();
        a_req = 1'b1; a_cmd = 3'd0;
        wait_ack(1'b0, 10, n, okv);
        chk("solo_a_lat", n, 2);
        a_req = 1'b0;
        repeat (5) tick();
        a_req = 1'b1; a_cmd = 3'd1; b_req = 1'b1; b_cmd = 3'd1;
        wait_ack(1'b1, 10, n, okv);
        chk("tie2_b_first", n, 2); chk("tie2_pBy", int'(pBy), 8);
        b_req = 1'b0;
        wait_ack(1'b0, 10, n, okv);
        chk("tie2_a_second", n, 3);
        a_req = 1'b0;

        // Grid edge: held request, accept then reject then immediate re-grant.
        do_reset();
        a_req = 1'b1; a_cmd = 3'd0;
        wait_ack(1'b0, 10, n, okv);
        chk("edge_lat", n, 2); chk("edge_ok", int'(okv), 1); chk("edge_pAy", int'(pAy), 0);
        wait_ack(1'b0, 20, n, okv);
        chk("edge_cd_gap", n, CD + 2); chk("edge_rej", int'(okv), 0); chk("edge_pAy2", int'(pAy), 0);
        wait_ack(1'b0, 20, n, okv);
        chk("edge_rej_gap", n, 3);
        a_req = 1'b0;

        // Blocked target cell.
        do_reset();
        arena_blocks[12] = 1'b1;
        a_req = 1'b1; a_cmd = 3'd3;
        wait_ack(1'b0, 10, n, okv);
        chk("blk_ok", int'(okv), 0); chk("blk_pAx", int'(pAx), 1);
        a_req = 1'b0; arena_blocks = '0;

        // Bomb strobe, then bomb refused while busy.
        do_reset();
        a_req = 1'b1; a_cmd = 3'd4;
        tick(); a_req = 1'b0;
        tick();
        chk("bomb_strobe", int'(bombA_v) * 2 + int'(a_ok), 3);
        chk("bomb_xy", int'(bombA_x) * 16 + int'(bombA_y), 17);
        tick();
        chk("bomb_one_cycle", int'(bombA_v), 0);
        repeat (CD) tick();
        bomb_busy_a = 1'b1; a_req = 1'b1;
        wait_ack(1'b0, 10, n, okv);
        chk("bomb_busy_rej", int'(okv) + int'(bombA_v), 0);
        a_req = 1'b0; bomb_busy_a = 1'b0;

        // No grants while play_en is low.
        play_en = 1'b0; a_req = 1'b1; a_cmd = 3'd1; acks = 0;
        repeat (20) begin tick(); acks += int'(a_ack); end
        chk("play_en_low", acks, 0);
        play_en = 1'b1;
        wait_ack(1'b0, 10, n, okv);
        chk("play_en_resume", n, 2);
        a_req = 1'b0;

        // Random traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (i % 64 == 0)
                for (int c = 0; c < 100; c++) arena_blocks[c] = ($urandom_range(0, 6) == 0);
            rst         = ($urandom_range(0, 399) == 0);
            play_en     = ($urandom_range(0, 15) != 0);
            a_req       = ($urandom_range(0, 2) != 0);
            b_req       = ($urandom_range(0, 2) != 0);
            a_cmd       = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            b_cmd       = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            bomb_busy_a = ($urandom_range(0, 1) == 0);
            bomb_busy_b = ($urandom_range(0, 1) == 0);
        end
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
